// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM with shared memory port, wait timeout and sticky trap.
// Optional addi support is enabled by defining MC_ADDI_EN.
module mips_multicycle_ctrl #(
    parameter int ALU_OP_W  = 3,
    parameter int TIMEOUT_W = 4,
    parameter int TIMEOUT   = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [5:0]          opcode,
    input  logic [5:0]          funct,
    input  logic                zero_flag,
    input  logic                mem_ready,
    output logic                ir_write,
    output logic                pc_write,
    output logic                i_or_d,
    output logic                mem_read,
    output logic                mem_write,
    output logic                mem_to_reg,
    output logic                reg_dst,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          pc_src,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                instr_done,
    output logic                trap,
    output logic [1:0]          trap_cause,
    output logic [3:0]          state_out
);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_FETCH     = 4'd1;
    localparam logic [3:0] S_DECODE    = 4'd2;
    localparam logic [3:0] S_MEM_ADR   = 4'd3;
    localparam logic [3:0] S_MEM_RD    = 4'd4;
    localparam logic [3:0] S_MEM_WB    = 4'd5;
    localparam logic [3:0] S_MEM_WR    = 4'd6;
    localparam logic [3:0] S_EXEC      = 4'd7;
    localparam logic [3:0] S_ALU_WB    = 4'd8;
    localparam logic [3:0] S_BRANCH    = 4'd9;
    localparam logic [3:0] S_JUMP      = 4'd10;
`ifdef MC_ADDI_EN
    localparam logic [3:0] S_ADDI_EXEC = 4'd11;
    localparam logic [3:0] S_ADDI_WB   = 4'd12;
`endif
    localparam logic [3:0] S_TRAP      = 4'd15;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;
    localparam logic [2:0] OP_NOP = 3'b101;

    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_J     = 6'b000010;
`ifdef MC_ADDI_EN
    localparam logic [5:0] OPC_ADDI  = 6'b001000;
`endif

    localparam logic [TIMEOUT_W-1:0] TO_VAL = TIMEOUT_W'(TIMEOUT);

    logic [3:0]           state_q, state_d;
    logic [TIMEOUT_W-1:0] wait_q, wait_d;
    logic [1:0]           cause_q, cause_d;
    logic [2:0]           op3;
    logic [2:0]           funct_op;
    logic                 funct_ok;
    logic                 timed_out;

    // Decode the R-type funct once; used both for legality in DECODE and the op in EXEC.
    always_comb begin
        funct_ok = 1'b1;
        funct_op = OP_NOP;
        case (funct)
            6'b100000: funct_op = OP_ADD;
            6'b100010: funct_op = OP_SUB;
            6'b100100: funct_op = OP_AND;
            6'b100101: funct_op = OP_OR;
            6'b101010: funct_op = OP_SLT;
            default:   funct_ok = 1'b0;
        endcase
    end

    assign timed_out = !mem_ready && (wait_q == TO_VAL);

    always_comb begin
        state_d    = state_q;
        cause_d    = cause_q;
        wait_d     = '0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        reg_dst    = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        pc_src     = 2'b00;
        instr_done = 1'b0;
        trap       = 1'b0;
        op3        = OP_NOP;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                // A timeout cycle issues no strobes at all, including the read.
                if (timed_out) begin
                    state_d = S_TRAP;
                    cause_d = 2'b10;
                end else begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    op3       = OP_ADD;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                    if (mem_ready) state_d = S_DECODE;
                    else           wait_d  = wait_q + 1'b1;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                op3       = OP_ADD;
                case (opcode)
                    OPC_RTYPE:      state_d = funct_ok ? S_EXEC : S_TRAP;
                    OPC_LW, OPC_SW: state_d = S_MEM_ADR;
                    OPC_BEQ:        state_d = S_BRANCH;
                    OPC_J:          state_d = S_JUMP;
`ifdef MC_ADDI_EN
                    OPC_ADDI:       state_d = S_ADDI_EXEC;
`endif
                    default:        state_d = S_TRAP;
                endcase
                if (state_d == S_TRAP) cause_d = 2'b01;
            end
            S_MEM_ADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                op3       = OP_ADD;
                state_d   = (opcode == OPC_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                if (timed_out) begin
                    state_d = S_TRAP;
                    cause_d = 2'b10;
                end else begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                    if (mem_ready) state_d = S_MEM_WB;
                    else           wait_d  = wait_q + 1'b1;
                end
            end
            S_MEM_WB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WR: begin
                if (timed_out) begin
                    state_d = S_TRAP;
                    cause_d = 2'b10;
                end else begin
                    mem_write  = 1'b1;
                    i_or_d     = 1'b1;
                    instr_done = mem_ready;
                    if (mem_ready) state_d = S_FETCH;
                    else           wait_d  = wait_q + 1'b1;
                end
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                op3       = funct_op;
                state_d   = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_dst    = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                op3        = OP_SUB;
                pc_src     = 2'b01;
                pc_write   = zero_flag;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_JUMP: begin
                pc_src     = 2'b10;
                pc_write   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
`ifdef MC_ADDI_EN
            S_ADDI_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                op3       = OP_ADD;
                state_d   = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
`endif
            S_TRAP:  trap = 1'b1;
            default: state_d = S_IDLE;
        endcase
        alu_op = ALU_OP_W'(op3);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
            cause_q <= 2'b00;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            cause_q <= cause_d;
        end
    end

    assign trap_cause = cause_q;
    assign state_out  = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed self-checking bench for mips_multicycle_ctrl (default parameters).
module tb_mips_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero_flag;
    logic       mem_ready;
    logic       ir_write, pc_write, i_or_d, mem_read, mem_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_op;
    logic       instr_done, trap;
    logic [1:0] trap_cause;
    logic [3:0] state_out;

    int total = 0;
    int bad   = 0;

    mips_multicycle_ctrl #(.ALU_OP_W(3), .TIMEOUT_W(4), .TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
        .zero_flag(zero_flag), .mem_ready(mem_ready),
        .ir_write(ir_write), .pc_write(pc_write), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
        .reg_dst(reg_dst), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .pc_src(pc_src), .alu_op(alu_op),
        .instr_done(instr_done), .trap(trap), .trap_cause(trap_cause),
        .state_out(state_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        #1;
        chk("rst_state", 32'(state_out), 32'd0);
        chk("rst_trap", 32'(trap), 32'd0);
        chk("rst_cause", 32'(trap_cause), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("rst_to_fetch", 32'(state_out), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; opcode = '0; funct = '0; zero_flag = 1'b0; mem_ready = 1'b0;
        #2;
        chk("reset_state", 32'(state_out), 32'd0);
        chk("reset_alu_op", 32'(alu_op), 32'h5);
        chk("reset_strobes", {ir_write, pc_write, mem_read, mem_write, reg_write, instr_done, trap},
            32'd0);
        chk("reset_cause", 32'(trap_cause), 32'd0);
        rst_n = 1'b1;

        // R-type add
        tick();
        chk("add_fetch_state", 32'(state_out), 32'd1);
        opcode = 6'b000000; funct = 6'b100000; mem_ready = 1'b1;
        settle();
        chk("fetch_strobes", {mem_read, ir_write, pc_write, i_or_d, alu_src_a}, 32'b11100);
        chk("fetch_srcb", 32'(alu_src_b), 32'd1);
        chk("fetch_alu_op", 32'(alu_op), 32'h2);
        tick();
        chk("add_decode", 32'(state_out), 32'd2);
        chk("decode_srcb", 32'(alu_src_b), 32'd3);
        tick();
        chk("add_exec", 32'(state_out), 32'd7);
        chk("exec_alu_op", 32'(alu_op), 32'h2);
        chk("exec_src", {alu_src_a, alu_src_b}, 32'b100);
        tick();
        chk("add_alu_wb", 32'(state_out), 32'd8);
        chk("alu_wb_strobes", {reg_dst, reg_write, instr_done, mem_to_reg}, 32'b1110);
        tick();
        chk("add_back_fetch", 32'(state_out), 32'd1);

        // R-type sub and slt ALU op
        funct = 6'b100010;
        tick(); tick();
        chk("sub_alu_op", 32'(alu_op), 32'h6);
        tick(); tick();
        funct = 6'b101010;
        tick(); tick();
        chk("slt_alu_op", 32'(alu_op), 32'h7);
        tick(); tick();

        // lw with three wait cycles in MEM_RD
        opcode = 6'b100011;
        tick();
        chk("lw_decode", 32'(state_out), 32'd2);
        tick();
        chk("lw_mem_adr", 32'(state_out), 32'd3);
        chk("mem_adr_src", {alu_src_a, alu_src_b}, 32'b110);
        mem_ready = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("lw_mem_rd_wait", 32'(state_out), 32'd4);
            chk("lw_mem_rd_strobes", {mem_read, i_or_d, instr_done}, 32'b110);
            tick();
        end
        mem_ready = 1'b1;
        settle();
        chk("lw_mem_rd_last", 32'(state_out), 32'd4);
        tick();
        chk("lw_mem_wb", 32'(state_out), 32'd5);
        chk("mem_wb_strobes", {mem_to_reg, reg_write, instr_done, reg_dst}, 32'b1110);
        tick();
        chk("lw_back_fetch", 32'(state_out), 32'd1);

        // sw
        opcode = 6'b101011;
        tick(); tick(); tick();
        chk("sw_mem_wr", 32'(state_out), 32'd6);
        chk("mem_wr_strobes", {mem_write, i_or_d, instr_done, mem_read}, 32'b1110);
        tick();
        chk("sw_back_fetch", 32'(state_out), 32'd1);

        // beq taken, then not taken
        opcode = 6'b000100; zero_flag = 1'b1;
        tick(); tick();
        chk("beq_state", 32'(state_out), 32'd9);
        chk("beq_taken_pcw", {pc_write, pc_src, instr_done}, 32'b1011);
        chk("beq_alu_op", 32'(alu_op), 32'h6);
        tick();
        chk("beq_back_fetch", 32'(state_out), 32'd1);
        zero_flag = 1'b0;
        tick(); tick();
        chk("beq_nt_pcw", {pc_write, instr_done}, 32'b01);
        tick();
        chk("beq_nt_back_fetch", 32'(state_out), 32'd1);

        // jump
        opcode = 6'b000010;
        tick(); tick();
        chk("j_state", 32'(state_out), 32'd10);
        chk("j_strobes", {pc_write, pc_src, instr_done}, 32'b1101);
        tick();

        // addi (trap unless the feature is built in)
        opcode = 6'b001000;
        tick(); tick();
`ifdef MC_ADDI_EN
        chk("addi_exec", 32'(state_out), 32'd11);
        chk("addi_exec_src", {alu_src_a, alu_src_b}, 32'b110);
        tick();
        chk("addi_wb", 32'(state_out), 32'd12);
        chk("addi_wb_strobes", {reg_dst, mem_to_reg, reg_write, instr_done}, 32'b0011);
        tick();
        chk("addi_back_fetch", 32'(state_out), 32'd1);
        reset_pulse();
`else
        chk("addi_trap", 32'(state_out), 32'd15);
        chk("addi_cause", 32'(trap_cause), 32'd1);
        reset_pulse();
`endif

        // illegal opcode
        opcode = 6'b111111;
        tick(); tick();
        chk("illop_state", 32'(state_out), 32'd15);
        chk("illop_trap", {trap, trap_cause}, 32'b101);
        chk("illop_strobes", {mem_read, pc_write, reg_write, instr_done}, 32'd0);
        tick();
        chk("illop_sticky", 32'(state_out), 32'd15);
        reset_pulse();

        // illegal funct
        opcode = 6'b000000; funct = 6'b000111;
        tick(); tick();
        chk("illfn_state", 32'(state_out), 32'd15);
        chk("illfn_cause", 32'(trap_cause), 32'd1);
        reset_pulse();

        // mem_ready arriving exactly at the timeout count completes normally
        mem_ready = 1'b0; opcode = 6'b000010;
        for (int i = 0; i < 15; i++) tick();
        chk("edge_still_fetch", 32'(state_out), 32'd1);
        mem_ready = 1'b1;
        tick();
        chk("edge_decode", 32'(state_out), 32'd2);
        tick(); tick();
        chk("edge_back_fetch", 32'(state_out), 32'd1);

        // fetch timeout: 16 FETCH cycles then TRAP
        mem_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk("to_fetch_hold", 32'(state_out), 32'd1);
            tick();
        end
        chk("to_trap_state", 32'(state_out), 32'd15);
        chk("to_trap_cause", {trap, trap_cause}, 32'b110);
        mem_ready = 1'b1;
        tick(); tick();
        chk("to_trap_sticky", 32'(state_out), 32'd15);
        chk("to_trap_strobes", {mem_read, ir_write, pc_write}, 32'd0);
        reset_pulse();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
